// File: rtl/divider_8x4_seq.sv
// rtl/divider_8x4_seq.sv - 8/4-bit sequential restoring divider with Start/Busy/Done handshake
// Signed (two's-complement) mode is compiled in only when DIVIDER_SIGNED_EN is defined.
module divider_8x4_seq (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start,
   input  logic [7:0] Dividend,
   input  logic [3:0] Divisor,
   input  logic       Sign,
   output logic [7:0] Quotient,
   output logic [3:0] Remainder,
   output logic       Busy,
   output logic       Done,
   output logic       Div_by_zero,
   output logic       Overflow
);

   typedef enum logic [1:0] {IDLE, DIV, FIX, ZERO} state_t;

   state_t     state, state_next;
   logic [2:0] count, count_next;
   logic [7:0] dvd_sh, dvd_sh_next;
   logic [3:0] dsr_mag, dsr_mag_next;
   logic [3:0] prem, prem_next;
   logic [7:0] quo, quo_next;
   logic [7:0] quotient_next;
   logic [3:0] remainder_next;
   logic       busy_next, done_next, dbz_next, ovf_next;

   logic [7:0] dvd_abs;
   logic [3:0] dsr_abs;
   logic [4:0] trial;
   logic       fits;
   logic [3:0] diff_lo;
   logic [7:0] fix_quo;
   logic [3:0] fix_rem;
   logic       fix_ovf;

`ifdef DIVIDER_SIGNED_EN
   logic q_neg, q_neg_next;
   logic r_neg, r_neg_next;
   logic ovf_pend, ovf_pend_next;
   logic dvd_neg_in, dsr_neg_in, ovf_in;

   assign dvd_neg_in = Sign & Dividend[7];
   assign dsr_neg_in = Sign & Divisor[3];
   assign ovf_in     = Sign && (Dividend == 8'h80) && (Divisor == 4'hF);
   assign dvd_abs    = dvd_neg_in ? (~Dividend + 8'd1) : Dividend;
   assign dsr_abs    = dsr_neg_in ? (~Divisor + 4'd1) : Divisor;
   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign fix_quo    = q_neg ? (~quo + 8'd1) : quo;
   assign fix_rem    = r_neg ? (~prem + 4'd1) : prem;
   assign fix_ovf    = ovf_pend;
`else
   logic sign_unused;

   assign sign_unused = Sign;
   assign dvd_abs     = Dividend;
   assign dsr_abs     = Divisor;
   assign fix_quo     = quo;
   assign fix_rem     = prem;
   assign fix_ovf     = 1'b0;
`endif

   // The stored remainder is always below the divisor, so 4 bits plus the
   // shifted-in dividend bit cover every trial value; a fitting difference
   // is below the divisor, so modulo-16 subtraction is exact.
   assign trial   = {prem, dvd_sh[7]};
   assign fits    = trial >= {1'b0, dsr_mag};
   assign diff_lo = trial[3:0] - dsr_mag;

   always_comb begin
      state_next     = state;
      count_next     = count;
      dvd_sh_next    = dvd_sh;
      dsr_mag_next   = dsr_mag;
      prem_next      = prem;
      quo_next       = quo;
      quotient_next  = Quotient;
      remainder_next = Remainder;
      busy_next      = Busy;
      done_next      = 1'b0;
      dbz_next       = Div_by_zero;
      ovf_next       = Overflow;
`ifdef DIVIDER_SIGNED_EN
      q_neg_next     = q_neg;
      r_neg_next     = r_neg;
      ovf_pend_next  = ovf_pend;
`endif
      case (state)
         IDLE: begin
            if (Start) begin
               busy_next    = 1'b1;
               count_next   = 3'd7;
               prem_next    = 4'h0;
               quo_next     = 8'h00;
               dsr_mag_next = dsr_abs;
`ifdef DIVIDER_SIGNED_EN
               q_neg_next    = dvd_neg_in ^ dsr_neg_in;
               r_neg_next    = dvd_neg_in;
               ovf_pend_next = ovf_in;
`endif
               // ZERO reports the raw low dividend nibble, so keep it unmodified.
               if (Divisor == 4'h0) begin
                  state_next  = ZERO;
                  dvd_sh_next = Dividend;
               end else begin
                  state_next  = DIV;
                  dvd_sh_next = dvd_abs;
               end
            end
         end
         DIV: begin
            prem_next   = fits ? diff_lo : trial[3:0];
            quo_next    = {quo[6:0], fits};
            dvd_sh_next = {dvd_sh[6:0], 1'b0};
            count_next  = count - 3'd1;
            if (count == 3'd0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            quotient_next  = fix_quo;
            remainder_next = fix_rem;
            dbz_next       = 1'b0;
            ovf_next       = fix_ovf;
            done_next      = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
         end
         ZERO: begin
            quotient_next  = 8'hFF;
            remainder_next = dvd_sh[3:0];
            dbz_next       = 1'b1;
            ovf_next       = 1'b0;
            done_next      = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         count       <= 3'd0;
         dvd_sh      <= 8'h00;
         dsr_mag     <= 4'h0;
         prem        <= 4'h0;
         quo         <= 8'h00;
         Quotient    <= 8'h00;
         Remainder   <= 4'h0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Div_by_zero <= 1'b0;
         Overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         ovf_pend    <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         count       <= count_next;
         dvd_sh      <= dvd_sh_next;
         dsr_mag     <= dsr_mag_next;
         prem        <= prem_next;
         quo         <= quo_next;
         Quotient    <= quotient_next;
         Remainder   <= remainder_next;
         Busy        <= busy_next;
         Done        <= done_next;
         Div_by_zero <= dbz_next;
         Overflow    <= ovf_next;
`ifdef DIVIDER_SIGNED_EN
         q_neg       <= q_neg_next;
         r_neg       <= r_neg_next;
         ovf_pend    <= ovf_pend_next;
`endif
      end
   end

endmodule

// File: tb/tb_divider_8x4_seq.sv
// tb/tb_divider_8x4_seq.sv - directed self-checking bench for divider_8x4_seq
// Signed expectations depend on whether DIVIDER_SIGNED_EN is defined.
module tb_divider_8x4_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'h00;
   logic [3:0] divisor = 4'h0;
   logic       sign = 1'b0;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy, done, div_by_zero, overflow;

   int checks = 0;
   int errors = 0;
   int lat, bcnt, dcnt;

   divider_8x4_seq dut (
      .Clk(clk), .Rst_n(rst_n), .Start(start), .Dividend(dividend), .Divisor(divisor),
      .Sign(sign), .Quotient(quotient), .Remainder(remainder), .Busy(busy), .Done(done),
      .Div_by_zero(div_by_zero), .Overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic launch(input logic [7:0] a, input logic [3:0] b, input logic s);
      dividend = a;
      divisor  = b;
      sign     = s;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      sign     = 1'($urandom);
   endtask

   // lat = edges after acceptance until Done is seen; -1 on timeout.
   task automatic wait_done(output int l, output int bc);
      l  = -1;
      bc = busy ? 1 : 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) bc++;
         if (done) begin
            l = k;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [3:0] b, input logic s,
                      input logic [7:0] eq, input logic [3:0] er, input logic ez, input logic eo,
                      input int elat);
      launch(a, b, s);
      check({tag, "_busy_after_accept"}, busy, 1);
      wait_done(lat, bcnt);
      check({tag, "_latency"}, lat, elat);
      check({tag, "_busy_cycles"}, bcnt, elat);
      check({tag, "_busy_with_done"}, busy, 0);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_div_by_zero"}, div_by_zero, ez);
      check({tag, "_overflow"}, overflow, eo);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run("u200_7", 8'd200, 4'd7, 1'b0, 8'h1C, 4'h4, 1'b0, 1'b0, 9);
      @(posedge clk);
      @(negedge clk);
      check("u200_7_done_falls", done, 0);

      run("u143_11", 8'h8F, 4'hB, 1'b0, 8'h0D, 4'h0, 1'b0, 1'b0, 9);
`ifdef DIVIDER_SIGNED_EN
      run("s_m100_7", 8'h9C, 4'h7, 1'b1, 8'hF2, 4'hE, 1'b0, 1'b0, 9);
      run("s_100_m8", 8'h64, 4'h8, 1'b1, 8'hF4, 4'h4, 1'b0, 1'b0, 9);
      run("s_ovf", 8'h80, 4'hF, 1'b1, 8'h80, 4'h0, 1'b0, 1'b1, 9);
      run("u_80_F", 8'h80, 4'hF, 1'b0, 8'h08, 4'h8, 1'b0, 1'b0, 9);
`else
      run("s_m100_7", 8'h9C, 4'h7, 1'b1, 8'h16, 4'h2, 1'b0, 1'b0, 9);
      run("s_100_m8", 8'h64, 4'h8, 1'b1, 8'h0C, 4'h4, 1'b0, 1'b0, 9);
      run("s_ovf", 8'h80, 4'hF, 1'b1, 8'h08, 4'h8, 1'b0, 1'b0, 9);
`endif
      run("zero", 8'h2A, 4'h0, 1'b0, 8'hFF, 4'hA, 1'b1, 1'b0, 1);
      run("after_zero", 8'd100, 4'd3, 1'b0, 8'h21, 4'h1, 1'b0, 1'b0, 9);

      // Start while busy must be ignored.
      launch(8'd200, 4'd7, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      dividend = 8'h8F;
      divisor  = 4'hB;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      check("ignore_latency", lat, 6);
      check("ignore_quotient", quotient, 8'h1C);
      check("ignore_remainder", remainder, 4'h4);
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("ignore_no_second_op", dcnt, 0);

      // Back-to-back: Start held during the Done cycle.
      launch(8'd77, 4'd5, 1'b0);
      wait_done(lat, bcnt);
      check("b2b_first_quotient", quotient, 8'h0F);
      check("b2b_first_remainder", remainder, 4'h2);
      launch(8'd255, 4'd15, 1'b0);
      check("b2b_accepted_busy", busy, 1);
      wait_done(lat, bcnt);
      check("b2b_second_latency", lat, 9);
      check("b2b_second_quotient", quotient, 8'h11);
      check("b2b_second_remainder", remainder, 4'h0);

      // Reset during DIV cycle 4.
      launch(8'd250, 4'd9, 1'b0);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("midrst_quotient", quotient, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_dbz", div_by_zero, 0);
      check("midrst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("midrst_no_done", dcnt, 0);

      run("post_rst", 8'd250, 4'd9, 1'b0, 8'h1B, 4'h7, 1'b0, 1'b0, 9);

      for (int i = 0; i < 50; i++) begin
         int a, b, qv, rv;
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(1, 15));
         launch(8'(a), 4'(b), 1'b0);
         wait_done(lat, bcnt);
         qv = int'(quotient);
         rv = int'(remainder);
         check("rnd_latency", lat, 9);
         check("rnd_quotient", qv, a / b);
         check("rnd_identity", ((qv * b + rv) == a) && (rv < b), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
